// File: rtl/sram_axi_slave.sv
// AXI4 slave bridging single-outstanding INCR bursts
// onto a single-port synchronous SRAM.
module sram_axi_slave #(
  parameter int IDW    = 8,
  parameter int ADDRW  = 32,
  parameter int DATAW  = 32,
  parameter int SRAMAW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDW-1:0]    AWID,
  input  logic [ADDRW-1:0]  AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATAW-1:0]  WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [IDW-1:0]    BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [IDW-1:0]    ARID,
  input  logic [ADDRW-1:0]  ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [IDW-1:0]    RID,
  output logic [DATAW-1:0]  RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [SRAMAW-1:0] A,
  output logic [DATAW-1:0]  DI,
  input  logic [DATAW-1:0]  DO
);

  typedef enum logic [2:0] {
    IDLE,
    R_FETCH,
    R_DATA,
    W_DATA,
    B_RESP
  } state_t;

  state_t            state;
  logic [IDW-1:0]    id_q;
  logic [SRAMAW-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;

  logic ar_hs;
  logic aw_hs;
  logic r_hs;
  logic w_hs;

  // Burst type, size and upper address bits are ignored.
  logic unused_in;
  assign unused_in = ^{AWLEN, AWSIZE, AWBURST,
                       ARSIZE, ARBURST,
                       AWADDR, ARADDR};

  assign ARREADY = (state == IDLE);
  assign AWREADY = (state == IDLE) && !ARVALID;
  assign WREADY  = (state == W_DATA);
  assign RVALID  = (state == R_DATA);
  assign BVALID  = (state == B_RESP);

  assign ar_hs = ARVALID && ARREADY;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign r_hs  = RVALID && RREADY;

  assign RID   = id_q;
  assign RDATA = DO;
  assign RRESP = 2'b00;
  assign RLAST = RVALID && (beat_q == len_q);
  assign BID   = id_q;
  assign BRESP = 2'b00;

  // SRAM strobes: one read cycle per fetch, writes pass straight through.
  always_comb begin
    CEB = 1'b1;
    WEB = 4'hF;
    A   = addr_q;
    DI  = '0;
    unique case (1'b1)
      (state == R_FETCH): begin
        CEB = 1'b0;
      end
      (state == W_DATA && WVALID): begin
        CEB = 1'b0;
        WEB = ~WSTRB;
        DI  = WDATA;
      end
      default: ;
    endcase
  end

  // Transaction FSM with latched ID, word address, length and beat count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            id_q   <= ARID;
            addr_q <= ARADDR[SRAMAW+1:2];
            len_q  <= ARLEN;
            beat_q <= '0;
            state  <= R_FETCH;
          end else if (aw_hs) begin
            id_q   <= AWID;
            addr_q <= AWADDR[SRAMAW+1:2];
            state  <= W_DATA;
          end
        end
        R_FETCH: state <= R_DATA;
        R_DATA: begin
          if (r_hs) begin
            if (RLAST) begin
              state <= IDLE;
            end else begin
              addr_q <= addr_q + 1'b1;
              beat_q <= beat_q + 1'b1;
              state  <= R_FETCH;
            end
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (WLAST) state <= B_RESP;
            else addr_q <= addr_q + 1'b1;
          end
        end
        B_RESP: begin
          if (BREADY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a
// behavioural synchronous SRAM model.
module tb_sram_axi_slave;

  logic        clk;
  logic        rst;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        CEB;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;

  logic [31:0] mem [0:16383];

  int checks;
  int passed;

  sram_axi_slave dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEB) begin
      if (WEB == 4'hF) begin
        DO <= mem[A];
      end else begin
        for (int b = 0; b < 4; b++)
          if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] ev);
    checks++;
    if (obs === ev) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, ev);
  endtask

  task automatic aw_send(input logic [31:0] ad,
                         input logic [7:0] id,
                         input logic [3:0] len);
    int n;
    n = 0;
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = ad; AWID = id; AWLEN = len;
    #1;
    while (!AWREADY && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_wait", (n < 20), 1'b1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d,
                        input logic [3:0] s,
                        input logic l,
                        input logic [13:0] ea);
    @(negedge clk);
    WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = l;
    #1;
    chk("w_ready", WREADY, 1'b1);
    chk("w_ceb", CEB, 1'b0);
    chk("w_web", WEB, 4'(~s));
    chk("w_addr", A, ea);
    chk("w_di", DI, d);
    chk("w_arready", ARREADY, 1'b0);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_recv(input logic [7:0] id);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!BVALID && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("b_wait", (n < 20), 1'b1);
    chk("b_id", BID, id);
    chk("b_resp", BRESP, 2'b00);
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] ad,
                         input logic [3:0] len,
                         input logic [7:0] id);
    int n;
    n = 0;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = ad; ARLEN = len; ARID = id;
    #1;
    while (!ARREADY && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("ar_wait", (n < 20), 1'b1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] ed,
                        input logic el,
                        input logic [7:0] eid);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!RVALID && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("r_wait", (n < 20), 1'b1);
    chk("r_data", RDATA, ed);
    chk("r_last", RLAST, el);
    chk("r_id", RID, eid);
    chk("r_resp", RRESP, 2'b00);
    chk("r_ceb", CEB, 1'b1);
    RREADY = 1'b1;
    @(posedge clk); #1;
    RREADY = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0;
    AWSIZE = 3'd0; AWBURST = 2'b00; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0;
    ARSIZE = 3'd1; ARBURST = 2'b10; ARVALID = 1'b0;
    RREADY = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_ceb", CEB, 1'b1);
    chk("rst_web", WEB, 4'hF);
    chk("rst_arready", ARREADY, 1'b1);
    chk("rst_awready", AWREADY, 1'b1);
    rst = 1'b1;

    aw_send(32'h0000_0010, 8'h05, 4'd0);
    @(negedge clk); #1;
    chk("widle_wready", WREADY, 1'b1);
    chk("widle_ceb", CEB, 1'b1);
    chk("widle_web", WEB, 4'hF);
    chk("wdata_awready", AWREADY, 1'b0);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1, 14'd4);
    b_recv(8'h05);
    ar_send(32'h0000_0010, 4'd0, 8'h06);
    r_beat(32'hDEAD_BEEF, 1'b1, 8'h06);

    aw_send(32'h0000_0020, 8'h11, 4'd0);
    w_beat(32'h1122_3344, 4'hF, 1'b1, 14'd8);
    b_recv(8'h11);
    aw_send(32'h0000_0020, 8'h12, 4'd0);
    w_beat(32'h0000_AB00, 4'b0010, 1'b1, 14'd8);
    b_recv(8'h12);
    ar_send(32'h0000_0020, 4'd0, 8'h13);
    r_beat(32'h1122_AB44, 1'b1, 8'h13);

    aw_send(32'h0000_0100, 8'h20, 4'd3);
    for (int i = 0; i < 4; i++)
      w_beat(32'hC0DE_0000 + i, 4'hF, (i == 3),
             14'd64 + 14'(i));
    b_recv(8'h20);

    ar_send(32'h0000_0100, 4'd3, 8'h21);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rb_fetch_rvalid", RVALID, 1'b0);
      chk("rb_fetch_ceb", CEB, 1'b0);
      chk("rb_fetch_web", WEB, 4'hF);
      chk("rb_fetch_addr", A, 14'd64 + 14'(i));
      @(negedge clk); #1;
      chk("rb_stall_rvalid", RVALID, 1'b1);
      chk("rb_stall_data", RDATA, 32'hC0DE_0000 + i);
      @(negedge clk); #1;
      chk("rb_hold_rvalid", RVALID, 1'b1);
      chk("rb_hold_data", RDATA, 32'hC0DE_0000 + i);
      chk("rb_last", RLAST, (i == 3));
      chk("rb_id", RID, 8'h21);
      RREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b0;
    end

    @(negedge clk);
    ARVALID = 1'b1; ARADDR = 32'h10; ARLEN = 4'd0;
    ARID = 8'h07;
    AWVALID = 1'b1; AWADDR = 32'h30; AWLEN = 4'd0;
    AWID = 8'h08;
    #1;
    chk("sim_arready", ARREADY, 1'b1);
    chk("sim_awready", AWREADY, 1'b0);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk); #1;
    chk("sim_fetch_awready", AWREADY, 1'b0);
    chk("sim_fetch_arready", ARREADY, 1'b0);
    @(negedge clk); #1;
    chk("sim_rvalid", RVALID, 1'b1);
    chk("sim_rdata", RDATA, 32'hDEAD_BEEF);
    chk("sim_rid", RID, 8'h07);
    chk("sim_data_awready", AWREADY, 1'b0);
    RREADY = 1'b1;
    @(posedge clk); #1;
    RREADY = 1'b0;
    @(negedge clk); #1;
    chk("sim_idle_awready", AWREADY, 1'b1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    w_beat(32'h5555_AAAA, 4'hF, 1'b1, 14'd12);
    b_recv(8'h08);

    aw_send(32'h0000_0034, 8'h09, 4'd0);
    w_beat(32'h0BAD_F00D, 4'hF, 1'b1, 14'd13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_bvalid", BVALID, 1'b1);
      chk("bp_bid", BID, 8'h09);
      chk("bp_awready", AWREADY, 1'b0);
      chk("bp_arready", ARREADY, 1'b0);
    end
    b_recv(8'h09);
    @(negedge clk); #1;
    chk("bp_after_arready", ARREADY, 1'b1);

    ar_send(32'h0000_0100, 4'd3, 8'h03);
    r_beat(32'hC0DE_0000, 1'b0, 8'h03);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_rvalid", RVALID, 1'b0);
    chk("mrst_ceb", CEB, 1'b1);
    chk("mrst_web", WEB, 4'hF);
    chk("mrst_arready", ARREADY, 1'b1);
    chk("mrst_wready", WREADY, 1'b0);
    chk("mrst_rid", RID, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    ar_send(32'h0000_0020, 4'd0, 8'h04);
    r_beat(32'h1122_AB44, 1'b1, 8'h04);

    aw_send(32'h0000_FFFC, 8'h01, 4'd0);
    w_beat(32'h1111_1111, 4'hF, 1'b0, 14'h3FFF);
    w_beat(32'h2222_2222, 4'hF, 1'b1, 14'h0000);
    b_recv(8'h01);
    ar_send(32'h0000_FFFC, 4'd1, 8'h0A);
    r_beat(32'h1111_1111, 1'b0, 8'h0A);
    r_beat(32'h2222_2222, 1'b1, 8'h0A);
    ar_send(32'h0000_0000, 4'd0, 8'h0B);
    r_beat(32'h2222_2222, 1'b1, 8'h0B);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
